// File: rtl/adc_regs_pkg.sv
// Shared definitions for the ADC AXI4-Lite register stage: register offsets,
// CTRL/STATUS bit positions, the AXI OKAY response code and the CTRL layout.
package adc_regs_pkg;

  // Byte offsets of the four word registers
  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_CLKDIV = 4'h4;
  localparam logic [3:0] ADDR_DATA   = 4'h8;
  localparam logic [3:0] ADDR_STATUS = 4'hC;

  // CTRL bit positions
  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;
  localparam int unsigned CTRL_CLEAR_BIT  = 2;
  localparam int unsigned CTRL_THR_LSB    = 3;
  localparam int unsigned CTRL_THR_MSB    = 7;

  // STATUS bit positions
  localparam int unsigned STATUS_LEVEL_MSB = 5;
  localparam int unsigned STATUS_EMPTY_BIT = 8;
  localparam int unsigned STATUS_FULL_BIT  = 9;
  localparam int unsigned STATUS_OVF_BIT   = 16;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef struct packed {
    logic [4:0] threshold;
    logic       fifo_clear;
    logic       irq_en;
    logic       enable;
  } ctrl_t;

endpackage

// File: rtl/adc_sample_fifo.sv
// Single-clock sample FIFO.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/data_i write side;
// pop_i read side (data_o shows the head entry combinationally); clear_i empties
// the FIFO and takes priority over push/pop; empty_o/full_o/level_o status.
module adc_sample_fifo #(
  parameter int unsigned Width = 12,
  parameter int unsigned Depth = 16,
  localparam int unsigned PtrW   = $clog2(Depth),
  localparam int unsigned LevelW = PtrW + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [Width-1:0]  data_i,
  input  logic              pop_i,
  input  logic              clear_i,
  output logic [Width-1:0]  data_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [LevelW-1:0] level_o
);

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] count_q, count_d;
  logic              push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == LevelW'(Depth));
  assign level_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when a pop frees the slot this cycle
  assign pop_ok  = pop_i & ~empty_o & ~clear_i;
  assign push_ok = push_i & ~clear_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + LevelW'(push_ok) - LevelW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/adc_axil_regs.sv
// AXI4-Lite register stage of the ADC peripheral.
// Ports: ACLK/ARESETN clock and async active-low reset; S_AXI_* AXI4-Lite slave
// (registers CTRL, CLKDIV, DATA, STATUS); sample_valid/sample_data from the ADC
// front end; adc_enable/adc_clkdiv to the front end; irq registered level interrupt.
module adc_axil_regs
  import adc_regs_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned SAMPLE_WIDTH       = 12,
  parameter int unsigned FIFO_DEPTH         = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]         sample_data,
  output logic                            adc_enable,
  output logic [15:0]                     adc_clkdiv,
  output logic                            irq
);

  localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;

  logic awready_q, awready_d, bvalid_q, bvalid_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  ctrl_t ctrl_q, ctrl_d;
  logic [15:0] clkdiv_q, clkdiv_d;
  logic clear_q, clear_d, ovf_q, ovf_d, irq_q, irq_d;

  logic wr_en, rd_en, push, pop;
  logic [3:0] wr_word, rd_word;
  logic [SAMPLE_WIDTH-1:0] fifo_rdata;
  logic fifo_empty, fifo_full;
  logic [LevelW-1:0] fifo_level;
  logic [5:0] level6;

  // Handshakes complete on the edge where the registered ready pulse meets valid
  assign wr_en   = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_en   = arready_q & S_AXI_ARVALID;
  assign wr_word = {S_AXI_AWADDR[3:2], 2'b00};
  assign rd_word = {S_AXI_ARADDR[3:2], 2'b00};
  assign push    = sample_valid & ctrl_q.enable;
  assign pop     = rd_en & (rd_word == ADDR_DATA) & ~fifo_empty;
  assign level6  = 6'(fifo_level);

  adc_sample_fifo #(
    .Width (SAMPLE_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (ACLK),
    .rst_ni  (ARESETN),
    .push_i  (push),
    .data_i  (sample_data),
    .pop_i   (pop),
    .clear_i (clear_q),
    .data_o  (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (fifo_level)
  );

  always_comb begin
    awready_d = ~awready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
    arready_d = ~arready_q & S_AXI_ARVALID & ~rvalid_q;
    bvalid_d  = bvalid_q;
    if (wr_en)                          bvalid_d = 1'b1;
    else if (bvalid_q && S_AXI_BREADY)  bvalid_d = 1'b0;
    rvalid_d  = rvalid_q;
    if (rd_en)                          rvalid_d = 1'b1;
    else if (rvalid_q && S_AXI_RREADY)  rvalid_d = 1'b0;

    ctrl_d   = ctrl_q;
    clkdiv_d = clkdiv_q;
    clear_d  = 1'b0;
    ovf_d    = ovf_q;
    if (wr_en) begin
      case (wr_word)
        ADDR_CTRL: if (S_AXI_WSTRB[0]) begin
          ctrl_d.enable    = S_AXI_WDATA[CTRL_ENABLE_BIT];
          ctrl_d.irq_en    = S_AXI_WDATA[CTRL_IRQ_EN_BIT];
          ctrl_d.threshold = S_AXI_WDATA[CTRL_THR_MSB:CTRL_THR_LSB];
          clear_d          = S_AXI_WDATA[CTRL_CLEAR_BIT];
        end
        ADDR_CLKDIV: begin
          if (S_AXI_WSTRB[0]) clkdiv_d[7:0]  = S_AXI_WDATA[7:0];
          if (S_AXI_WSTRB[1]) clkdiv_d[15:8] = S_AXI_WDATA[15:8];
        end
        ADDR_STATUS: if (S_AXI_WSTRB[2] && S_AXI_WDATA[STATUS_OVF_BIT]) ovf_d = 1'b0;
        default: ;
      endcase
    end
    // A dropped sample sets overflow even against a simultaneous W1C
    if (push && fifo_full && !pop) ovf_d = 1'b1;

    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = '0;
      case (rd_word)
        ADDR_CTRL: begin
          rdata_d[CTRL_ENABLE_BIT]           = ctrl_q.enable;
          rdata_d[CTRL_IRQ_EN_BIT]           = ctrl_q.irq_en;
          rdata_d[CTRL_THR_MSB:CTRL_THR_LSB] = ctrl_q.threshold;
        end
        ADDR_CLKDIV: rdata_d[15:0] = clkdiv_q;
        ADDR_DATA: if (!fifo_empty) begin
          rdata_d[C_S_AXI_DATA_WIDTH-1]  = 1'b1;
          rdata_d[SAMPLE_WIDTH-1:0]      = fifo_rdata;
        end
        ADDR_STATUS: begin
          rdata_d[STATUS_LEVEL_MSB:0] = level6;
          rdata_d[STATUS_EMPTY_BIT]   = fifo_empty;
          rdata_d[STATUS_FULL_BIT]    = fifo_full;
          rdata_d[STATUS_OVF_BIT]     = ovf_q;
        end
        default: ;
      endcase
    end

    irq_d = ctrl_q.irq_en &
            (((|ctrl_q.threshold) & (level6 >= {1'b0, ctrl_q.threshold})) | ovf_q);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      clkdiv_q  <= '0;
      clear_q   <= 1'b0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      clkdiv_q  <= clkdiv_d;
      clear_q   <= clear_d;
      ovf_q     <= ovf_d;
      irq_q     <= irq_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign adc_enable    = ctrl_q.enable;
  assign adc_clkdiv    = clkdiv_q;
  assign irq           = irq_q;

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                         S_AXI_WDATA[31:17], S_AXI_WSTRB[3], ctrl_q.fifo_clear};

endmodule

// File: doc/adc_axil_regs.md
Name: adc_axil_regs

Overview:
AXI4-Lite slave register stage of the myADCip peripheral. It sits between the AXI interconnect (the BFM master in simulation) and the ADC capture front end. It holds the control and clock-divider registers that drive the front end. It buffers incoming samples in a small FIFO that software drains by reading the DATA register, and it reports FIFO status and an interrupt.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
C_S_AXI_ADDR_WIDTH, 4, AXI address width (4 word registers)
SAMPLE_WIDTH, 12, ADC sample width (1..16)
FIFO_DEPTH, 16, sample FIFO depth (power of 2, 2..32)

Ports:
ACLK  in  1  single clock for the block
ARESETN  in  1  asynchronous, active-low reset
S_AXI_AWADDR  in  4  write address (byte)
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  write address handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID/S_AXI_WREADY  in/out  1  write data handshake
S_AXI_BRESP  out  2  always OKAY (2'b00)
S_AXI_BVALID/S_AXI_BREADY  out/in  1  write response handshake
S_AXI_ARADDR  in  4  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  read address handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always OKAY
S_AXI_RVALID/S_AXI_RREADY  out/in  1  read data handshake
sample_valid  in  1  one-cycle strobe from the ADC front end
sample_data  in  SAMPLE_WIDTH  sample value
adc_enable  out  1  CTRL.enable to the front end
adc_clkdiv  out  16  CLKDIV value to the front end
irq  out  1  level interrupt, registered

Behaviour:
- Reset (ARESETN low, asynchronous): all AXI outputs 0; CTRL=0; CLKDIV=0; FIFO empty; overflow=0; irq=0.
- Register map, word-aligned; ADDR[1:0] ignored:
  - 0x0 CTRL, RW: [0] enable, [1] irq_en, [2] fifo_clear (write-1 pulse, reads 0), [7:3] threshold (0 disables the level interrupt).
  - 0x4 CLKDIV, RW: [15:0]; [31:16] read 0.
  - 0x8 DATA, RO: [SAMPLE_WIDTH-1:0] sample, [31] valid. Reading pops one entry. Reading when empty returns 0 with no pop.
  - 0xC STATUS: [5:0] level, [8] empty, [9] full, [16] overflow (sticky, write-1-to-clear). Other bits read-only.
- Writes to RO fields are ignored. All responses are OKAY.
- WSTRB is honoured per byte on CTRL and CLKDIV.
- Write channel:
  - AWREADY and WREADY pulse together for 1 cycle when AWVALID & WVALID & !BVALID. The register updates on that edge.
  - BVALID rises the next cycle and holds until BREADY.
  - AW without W, or W without AW, is not accepted; the block waits for both.
- Read channel:
  - ARREADY pulses 1 cycle when ARVALID & !RVALID. RDATA is registered on that edge, and the FIFO pop happens on that same edge.
  - RVALID rises the next cycle and holds, with RDATA stable, until RREADY.
  - Read latency from ARVALID to RVALID is 2 cycles. At most one outstanding read and one outstanding write.
- FIFO push:
  - Push occurs when sample_valid & adc_enable.
  - Push when full without a simultaneous pop: sample dropped, overflow set.
  - Push and pop in the same cycle when full: both happen, no overflow. Level is unchanged.
  - Push and pop in the same cycle when empty: the pop returns empty (valid=0) and the push lands.
- fifo_clear:
  - Empties the FIFO in the cycle after the write.
  - A push in that same cycle is discarded (clear wins).
  - Overflow is unaffected by fifo_clear.
- Overflow: if set and W1C occur in the same cycle, set wins.
- irq, registered one cycle after the cause: irq = irq_en & ((threshold!=0 & level>=threshold) | overflow).
- Level, pointers and count are modulo-FIFO_DEPTH pointers with a separate count of width clog2(FIFO_DEPTH)+1.

Decomposition:
- Package adc_regs_pkg holds:
  - register offsets (ADDR_CTRL, ADDR_CLKDIV, ADDR_DATA, ADDR_STATUS);
  - CTRL and STATUS bit-position constants;
  - RESP_OKAY;
  - a typedef for the CTRL struct.
- Sub-module adc_sample_fifo is synchronous, single clock, with push/pop/clear inputs and data/empty/full/level outputs. It has no overflow logic; overflow stays in the parent.

Test Plan:
- Reset, then write 0x0=0x3, 0x4=0x0031 and read back -> CTRL reads 0x3; adc_enable=1; adc_clkdiv=0x0031.
- WSTRB=4'b0001 write of 0x0000_AB12 to CLKDIV holding 0x0031 -> reads 0x0012.
- Enable, push samples 0x001,0x002,0x003; read DATA x4 -> 0x8000_0001, 0x8000_0002, 0x8000_0003, then 0x0000_0000; STATUS level goes 3→0 with empty=1.
- Push 17 samples with FIFO_DEPTH=16 -> STATUS=0x0001_0210 (overflow, full, level 16). Write 0xC=0x0001_0000 -> overflow clears. Repeat with a push in the W1C cycle while full -> overflow stays 1.
- threshold=4, irq_en=1, push 4 samples -> irq high 1 cycle after the 4th push. One DATA read -> irq low.
- Hold RREADY low 5 cycles after a DATA read -> RVALID and RDATA stable. Only one pop occurs (level drops by 1). Assert ARESETN low mid-hold -> RVALID=0 and FIFO empty immediately.
